// File: rtl/arb3_pkg.sv
// Shared types, select encodings and the round-robin pick for the three-way arbiter.
package arb3_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   localparam int         NUM_REQ = 3;
   localparam logic [1:0] SEL_D0  = 2'b00;
   localparam logic [1:0] SEL_D1  = 2'b01;
   localparam logic [1:0] SEL_D2  = 2'b10;

   // First pending requester in the order ptr, ptr+1, ptr+2 (mod 3); ptr when none pending.
   function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [1:0]         ptr);
      logic [1:0] win;
      logic       found;
      int         j;
      win   = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[j]) begin
            win   = 2'(j);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [1:0] next_ptr(input logic [1:0] w);
      return (w == SEL_D2) ? SEL_D0 : w + 2'd1;
   endfunction

   function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [1:0] s);
      return NUM_REQ'(1) << s;
   endfunction

endpackage

// File: rtl/mux3_1.sv
// Three-input multiplexer; the unused select code 11 falls back to a0.
module mux3_1 #(
   parameter int N = 32
) (
   input  logic [1:0]   sel,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] a2,
   output logic [N-1:0] y
);

   // NOTE: a default before the case keeps this purely combinational (no latch).
   always_comb begin
      y = a0;
      case (sel)
         2'b01:   y = a1;
         2'b10:   y = a2;
         default: y = a0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter3.sv
// Round-robin arbiter sharing one sink among three valid/ready requesters,
// with burst release on last or after MAX_BEATS accepted beats.
module rr_arbiter3
   import arb3_pkg::*;
#(
   parameter int N         = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid,
   input  logic [NUM_REQ-1:0] last,
   input  logic [N-1:0]       d0,
   input  logic [N-1:0]       d1,
   input  logic [N-1:0]       d2,
   output logic [NUM_REQ-1:0] ready,
   output logic [N-1:0]       y,
   output logic               y_valid,
   output logic               y_last,
   input  logic               y_ready,
   output logic [NUM_REQ-1:0] gnt,
   output logic [1:0]         sel,
   output logic               busy,
   output logic               preempt
);

   localparam int CW = $clog2(MAX_BEATS + 1);

   arb_state_t         state_q,   state_d;
   logic [NUM_REQ-1:0] gnt_q,     gnt_d;
   logic [1:0]         sel_q,     sel_d;
   logic [1:0]         ptr_q,     ptr_d;
   logic               busy_q,    busy_d;
   logic               preempt_q, preempt_d;
   logic [CW-1:0]      cnt_q,     cnt_d;

   logic       last_w;
   logic       at_max;
   logic       accept;
   logic       rel;
   logic [1:0] win;

   mux3_1 #(.N(N)) u_data_mux (
      .sel (sel_q),
      .a0  (d0),
      .a1  (d1),
      .a2  (d2),
      .y   (y)
   );

   mux3_1 #(.N(1)) u_last_mux (
      .sel (sel_q),
      .a0  (last[0]),
      .a1  (last[1]),
      .a2  (last[2]),
      .y   (last_w)
   );

   // Sink-side handshake is combinational off the registered select.
   assign y_valid = (state_q == BUSY) && valid[sel_q];
   assign ready   = gnt_q & {NUM_REQ{y_ready}};
   assign accept  = y_valid && y_ready;
   assign at_max  = (cnt_q == CW'(MAX_BEATS - 1));
   assign y_last  = y_valid && (last_w || at_max);
   assign rel     = accept && (last_w || at_max);
   assign win     = rr_pick(valid, ptr_q);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|valid) begin
               state_d = BUSY;
               sel_d   = win;
               gnt_d   = sel_to_onehot(win);
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (accept) begin
               cnt_d = cnt_q + CW'(1);
               if (rel) begin
                  state_d   = IDLE;
                  gnt_d     = '0;
                  sel_d     = SEL_D0;
                  busy_d    = 1'b0;
                  ptr_d     = next_ptr(sel_q);
                  cnt_d     = '0;
                  preempt_d = !last_w;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         sel_q     <= SEL_D0;
         ptr_q     <= SEL_D0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
         cnt_q     <= cnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign busy    = busy_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Directed bench for rr_arbiter3: a vector table for the single-requester burst,
// then hand-written rotation, forced-release, backpressure and reset sequences.
module tb_rr_arbiter3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  valid = '0, last = '0;
   logic [31:0] d0 = 32'hD0, d1 = 32'hD1, d2 = 32'hD2;
   logic        y_ready = 1'b0;

   logic [2:0]  ready, gnt;
   logic [31:0] y;
   logic        y_valid, y_last, busy, preempt;
   logic [1:0]  sel;

   logic [2:0]  m1_ready, m1_gnt;
   logic [31:0] m1_y;
   logic        m1_y_valid, m1_y_last, m1_busy, m1_preempt;
   logic [1:0]  m1_sel;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_arbiter3 #(.N(32), .MAX_BEATS(4)) u_dut (
      .clk(clk), .rst(rst), .valid(valid), .last(last),
      .d0(d0), .d1(d1), .d2(d2),
      .ready(ready), .y(y), .y_valid(y_valid), .y_last(y_last), .y_ready(y_ready),
      .gnt(gnt), .sel(sel), .busy(busy), .preempt(preempt)
   );

   rr_arbiter3 #(.N(32), .MAX_BEATS(1)) u_dut_m1 (
      .clk(clk), .rst(rst), .valid(valid), .last(last),
      .d0(d0), .d1(d1), .d2(d2),
      .ready(m1_ready), .y(m1_y), .y_valid(m1_y_valid), .y_last(m1_y_last), .y_ready(y_ready),
      .gnt(m1_gnt), .sel(m1_sel), .busy(m1_busy), .preempt(m1_preempt)
   );

   typedef struct {
      logic [2:0]  valid;
      logic [2:0]  last;
      logic        y_ready;
      logic [31:0] d1;
      logic [2:0]  gnt;
      logic [1:0]  sel;
      logic        busy;
      logic        y_valid;
      logic [31:0] y;
      logic        y_last;
      logic [2:0]  ready;
      logic        preempt;
      logic [2:0]  m1_gnt;
      logic        m1_y_last;
      logic        m1_preempt;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = '0; last = '0; y_ready = 1'b0;
      d0 = 32'hD0; d1 = 32'hD1; d2 = 32'hD2;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [2:0]  rot_gnt [8];
   logic [31:0] rot_y   [8];

   initial begin
      //           valid   last    yr    d1      | gnt    sel    bsy   yv    y       yl    rdy     pre  | m1 gnt yl    pre
      tbl[0] = '{3'b010, 3'b000, 1'b1, 32'hA1, 3'b000, 2'b00, 1'b0, 1'b0, 32'hD0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[1] = '{3'b010, 3'b000, 1'b1, 32'hA1, 3'b010, 2'b01, 1'b1, 1'b1, 32'hA1, 1'b0, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0};
      tbl[2] = '{3'b010, 3'b000, 1'b1, 32'hA2, 3'b010, 2'b01, 1'b1, 1'b1, 32'hA2, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b1};
      tbl[3] = '{3'b010, 3'b010, 1'b1, 32'hA3, 3'b010, 2'b01, 1'b1, 1'b1, 32'hA3, 1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0};
      tbl[4] = '{3'b000, 3'b000, 1'b1, 32'hA3, 3'b000, 2'b00, 1'b0, 1'b0, 32'hD0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[5] = '{3'b111, 3'b111, 1'b1, 32'hA3, 3'b000, 2'b00, 1'b0, 1'b0, 32'hD0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[6] = '{3'b111, 3'b111, 1'b1, 32'hA3, 3'b100, 2'b10, 1'b1, 1'b1, 32'hD2, 1'b1, 3'b100, 1'b0, 3'b100, 1'b1, 1'b0};

      rot_gnt = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      rot_y   = '{32'hD0, 32'hD0, 32'hD0, 32'hD1, 32'hD0, 32'hD2, 32'hD0, 32'hD0};

      // Reset values while rst is held.
      #1;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_preempt", 32'(preempt), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_y_valid", 32'(y_valid), 32'h0);
      check("rst_y_last", 32'(y_last), 32'h0);

      // Single requester 1 burst, then all three request to expose ptr=2.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         valid = tbl[i].valid; last = tbl[i].last; y_ready = tbl[i].y_ready; d1 = tbl[i].d1;
         #1;
         check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         check($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
         check($sformatf("tbl%0d_y_valid", i), 32'(y_valid), 32'(tbl[i].y_valid));
         check($sformatf("tbl%0d_y", i), y, tbl[i].y);
         check($sformatf("tbl%0d_y_last", i), 32'(y_last), 32'(tbl[i].y_last));
         check($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].ready));
         check($sformatf("tbl%0d_preempt", i), 32'(preempt), 32'(tbl[i].preempt));
         check($sformatf("tbl%0d_m1_gnt", i), 32'(m1_gnt), 32'(tbl[i].m1_gnt));
         check($sformatf("tbl%0d_m1_y_last", i), 32'(m1_y_last), 32'(tbl[i].m1_y_last));
         check($sformatf("tbl%0d_m1_preempt", i), 32'(m1_preempt), 32'(tbl[i].m1_preempt));
         step();
      end

      // Rotation: all three send single-beat bursts from reset.
      do_reset();
      valid = 3'b111; last = 3'b111; y_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("rot%0d_gnt", i), 32'(gnt), 32'(rot_gnt[i]));
         check($sformatf("rot%0d_y", i), y, rot_y[i]);
         step();
      end

      // Forced release after 4 beats of requester 2.
      do_reset();
      valid = 3'b100; last = 3'b000; y_ready = 1'b1; d2 = 32'hB1;
      #1; check("frc_idle_gnt", 32'(gnt), 32'h0);
      step();
      valid = 3'b111; last = 3'b011;
      for (int b = 1; b <= 4; b++) begin
         d2 = 32'hB0 + 32'(b);
         #1;
         check($sformatf("frc_b%0d_gnt", b), 32'(gnt), 32'h4);
         check($sformatf("frc_b%0d_y", b), y, 32'hB0 + 32'(b));
         check($sformatf("frc_b%0d_y_last", b), 32'(y_last), (b == 4) ? 32'h1 : 32'h0);
         check($sformatf("frc_b%0d_preempt", b), 32'(preempt), 32'h0);
         step();
      end
      d2 = 32'hB5;
      #1;
      check("frc_rel_gnt", 32'(gnt), 32'h0);
      check("frc_rel_preempt", 32'(preempt), 32'h1);
      check("frc_rel_y_valid", 32'(y_valid), 32'h0);
      step();
      #1;
      check("frc_g0_gnt", 32'(gnt), 32'h1);
      check("frc_g0_y", y, 32'hD0);
      check("frc_g0_preempt", 32'(preempt), 32'h0);
      step();
      #1; check("frc_gap1_gnt", 32'(gnt), 32'h0);
      step();
      #1;
      check("frc_g1_gnt", 32'(gnt), 32'h2);
      check("frc_g1_y", y, 32'hD1);
      step();
      valid = 3'b100; last = 3'b000;
      #1; check("frc_gap2_gnt", 32'(gnt), 32'h0);
      step();
      #1;
      check("frc_g2_gnt", 32'(gnt), 32'h4);
      check("frc_b5_y", y, 32'hB5);
      check("frc_b5_y_last", 32'(y_last), 32'h0);
      step();
      d2 = 32'hB6; last = 3'b100;
      #1;
      check("frc_b6_y", y, 32'hB6);
      check("frc_b6_y_last", 32'(y_last), 32'h1);
      step();
      valid = 3'b000; last = 3'b000;
      #1;
      check("frc_end_gnt", 32'(gnt), 32'h0);
      check("frc_end_preempt", 32'(preempt), 32'h0);

      // Backpressure: y_ready low for 5 cycles on beat 2 of requester 0.
      do_reset();
      valid = 3'b001; last = 3'b000; y_ready = 1'b1; d0 = 32'hC1;
      step();
      #1;
      check("bp_b1_gnt", 32'(gnt), 32'h1);
      check("bp_b1_y", y, 32'hC1);
      check("bp_b1_ready", 32'(ready), 32'h1);
      step();
      d0 = 32'hC2; y_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         #1;
         check($sformatf("bp_st%0d_ready", s), 32'(ready), 32'h0);
         check($sformatf("bp_st%0d_y", s), y, 32'hC2);
         check($sformatf("bp_st%0d_gnt", s), 32'(gnt), 32'h1);
         check($sformatf("bp_st%0d_y_last", s), 32'(y_last), 32'h0);
         step();
      end
      y_ready = 1'b1;
      #1;
      check("bp_b2_ready", 32'(ready), 32'h1);
      check("bp_b2_y", y, 32'hC2);
      check("bp_b2_y_last", 32'(y_last), 32'h0);
      step();
      d0 = 32'hC3; last = 3'b001;
      #1;
      check("bp_b3_y", y, 32'hC3);
      check("bp_b3_y_last", 32'(y_last), 32'h1);
      step();
      valid = 3'b000; last = 3'b000; d0 = 32'hD0;
      #1;
      check("bp_end_gnt", 32'(gnt), 32'h0);
      check("bp_end_preempt", 32'(preempt), 32'h0);

      // Asynchronous reset during beat 2 of a requester-1 burst.
      do_reset();
      valid = 3'b010; last = 3'b000; y_ready = 1'b1; d1 = 32'hE1;
      step();
      #1; check("rm_b1_gnt", 32'(gnt), 32'h2);
      step();
      d1 = 32'hE2;
      #1; check("rm_b2_y_valid", 32'(y_valid), 32'h1);
      #2; rst = 1'b1;
      #1;
      check("rm_rst_gnt", 32'(gnt), 32'h0);
      check("rm_rst_y_valid", 32'(y_valid), 32'h0);
      check("rm_rst_busy", 32'(busy), 32'h0);
      check("rm_rst_ready", 32'(ready), 32'h0);
      check("rm_rst_y", y, 32'hD0);
      step();
      rst = 1'b0; valid = 3'b011; last = 3'b011;
      #1; check("rm_post_idle_gnt", 32'(gnt), 32'h0);
      step();
      #1; check("rm_post_gnt", 32'(gnt), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter3.md
# rr_arbiter3

Round-robin arbiter that shares one downstream sink (memory port, UART TX, bus) among three requesters. Each requester offers N-bit beats under a valid/ready handshake with a `last` marker. The block grants one requester per burst, drives the select of an internal 3:1 data multiplexer, and releases the grant at end of burst or after a beat-count limit.

## Interface
- `N`, 32, data width in bits.
- `MAX_BEATS`, 16, maximum accepted beats per grant before forced release; must be ≥ 1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid`  in  3  per-requester beat valid; bit i belongs to requester i.
- `last`  in  3  per-requester end-of-burst marker, qualified by `valid[i]`.
- `d0`, `d1`, `d2`  in  N each  requester data.
- `ready`  out  3  per-requester beat accepted.
- `y`  out  N  data to sink.
- `y_valid`  out  1  beat valid to sink.
- `y_last`  out  1  end of granted burst, natural or forced.
- `y_ready`  in  1  sink ready.
- `gnt`  out  3  one-hot current grant; `000` when idle.
- `sel`  out  2  mux select: `00`=d0, `01`=d1, `10`=d2; `11` is never driven.
- `busy`  out  1  high while a grant is held.
- `preempt`  out  1  one-cycle pulse when a grant is force-released by `MAX_BEATS`.

## Operation
- States are IDLE and BUSY.
- Reset values: state IDLE, `gnt=000`, `sel=00`, `busy=0`, `preempt=0`, `ready=000`, `y_valid=0`, `y_last=0`, priority pointer `ptr=0`, beat counter 0.
- **IDLE:** pending requests are the bits of `valid`.
  - The winner is the first pending requester in the order `ptr`, `ptr+1`, `ptr+2` (mod 3).
  - If any request is pending: register `gnt`/`sel` for the winner, clear the counter, and go to BUSY.
  - If none is pending: stay in IDLE.
- **BUSY**, with winner w:
  - `y = d_w` through the mux.
  - `y_valid = valid[w]`.
  - `ready[w] = y_ready`; all other `ready` bits are 0.
  - A beat is accepted when `y_valid && y_ready`; each accepted beat increments the counter.
- **Release** happens on an accepted beat when either condition holds:
  - `last[w]=1`, or
  - the counter reaches `MAX_BEATS` on this beat.
  - `y_last` is 1 on that beat (combinational).
  - At the edge: state goes to IDLE, `gnt=000`, `ptr=(w+1) mod 3`.
  - `preempt` pulses the cycle after the edge only for a count release with `last[w]=0`.
- If `valid[w]` drops mid-burst, the grant is held and no timeout applies.
- Requests from non-granted requesters never affect the current grant.
- In IDLE, `y_valid=0` and `y` shows `d0`.

## Timing
- Arbitration latency: 1 cycle. The first beat of a grant can be accepted in the cycle after the request is first seen in IDLE.
- After a release there is a minimum 1-cycle IDLE gap before the next grant.
- The `ready`/`y_valid`/`y`/`y_last` path is combinational from the inputs and the registered `sel`; it contains no register.
- `gnt`, `sel`, `busy` and `preempt` are registered outputs.
- Counter width is `$clog2(MAX_BEATS+1)`; the counter never wraps, because release occurs at `MAX_BEATS`.
- `MAX_BEATS=1`: every accepted beat releases the grant.
- `rst` asserted mid-burst: all outputs return to reset values immediately (asynchronous), and `ptr=0`.
- A release and a new request in the same cycle: the new request is evaluated in the following IDLE cycle with the updated `ptr`.

## Structure
- Package `arb3_pkg` holds:
  - `typedef enum logic {IDLE, BUSY} arb_state_t`;
  - constants `SEL_D0=2'b00`, `SEL_D1=2'b01`, `SEL_D2=2'b10`;
  - `NUM_REQ=3`.
- Sub-modules:
  - the existing `mux3_1` (parameter N), instantiated once for `y`;
  - a second instance with N=1 for selecting `last`.
- The round-robin pick is a function in `arb3_pkg`.

## Test plan
- **Single requester:** reset, then requester 1 sends 3 beats `0xA1,0xA2,0xA3` with `last` on the third and `y_ready=1`.
  - `gnt=010` and `sel=01` one cycle after valid.
  - `y` shows the 3 beats in 3 cycles, with `y_last` on `0xA3`.
  - `gnt=000` the next cycle, then `ptr=2`.
- **Rotation:** all three requesters send single-beat bursts continuously from reset.
  - Grant order is 0, 1, 2, 0, with one IDLE cycle between grants.
- **Forced release:** `MAX_BEATS=4`; requester 2 streams 6 beats with `last` only on the 6th.
  - Release after the 4th accepted beat, with `y_last=1` on it and a `preempt` pulse.
  - Requester 2 is regranted only after 0 and 1 if those are pending.
- **Backpressure:** `y_ready` low for 5 cycles mid-burst.
  - Counter, grant and `y` are held; `ready[w]=0`; no beat is lost or duplicated.
- **Reset mid-burst:** assert `rst` during beat 2 of a requester-1 burst.
  - `gnt=000`, `y_valid=0`, `busy=0` in the same cycle.
  - After release, requester 0 wins over 1 when both request.
